data_memory: RTL and testbench
==============================

# data_memory

Single-port 128 x 8 synchronous data memory, the module instantiated as `memory`, behind the four-channel memory controller. It accepts one read or write request at a time from the controller's multiplexed request lines. It completes each request after a fixed, parameterised number of clock edges and signals completion with a one-cycle `ready` pulse. The read result is held on `output_data` until the next read completes.

## Interface
- `ADDR_WIDTH`, default 7: address width; depth is 2^ADDR_WIDTH words (128).
- `DATA_WIDTH`, default 8: word width.
- `LATENCY`, default 2: number of clock edges from request acceptance to completion, including the accepting edge; legal range 1..15.

Ports:
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `en` input 1: request enable.
- `read` input 1: read request.
- `write` input 1: write request.
- `address` input ADDR_WIDTH: word address.
- `input_data` input DATA_WIDTH: write data.
- `output_data` output DATA_WIDTH: registered read data.
- `ready` output 1: completion pulse.

## Operation
- Valid request: `en`=1 and exactly one of `read`/`write` is 1. Any other combination is no request.
- State machine with states IDLE, WAIT and DONE. The reset state is IDLE.
- **IDLE**
  - On a valid request at a rising edge, latch `address`, `input_data` and the operation.
  - If LATENCY=1, perform the access on that same edge and go to DONE.
  - Otherwise load the wait counter with LATENCY-1 and go to WAIT.
  - No request: stay in IDLE, memory unchanged.
- **WAIT**
  - Each edge decrements the counter.
  - Request inputs are ignored; the latched copies are used.
  - If `en`=0 at an edge in WAIT, abort: go to IDLE with no access and no `ready`.
  - When the counter reaches 0 at an edge, perform the access on that edge and go to DONE.
- **Access**
  - Write: `mem[addr] <= data`; `output_data` is unchanged.
  - Read: `output_data <= mem[addr]`.
  - Both use the latched values.
- **DONE**
  - `ready`=1 for exactly this cycle.
  - The next edge always returns to IDLE, even if a request is present.
  - A request still held at that edge is therefore not accepted until the following edge.
  - A held request is serviced as a new, repeated access.
- `output_data` holds the last read value indefinitely; writes, aborts and idle cycles never change it.
- Read-after-write to the same address returns the new data, because the write completes before the next request is accepted.
- Memory array contents are not affected by `reset` and are undefined until written.

## Timing
- Reset values, applied immediately on `reset`=1 independent of `clk`:
  - state is IDLE
  - `ready`=0
  - `output_data`=0
  - wait counter is 0
  - latched request registers are 0
- `ready` and `output_data` are register outputs with no combinational path from inputs.
- Let E0 be the accepting edge. The access and the `ready` rise occur at edge E0+(LATENCY-1). `ready` falls at the next edge.
- Maximum throughput is one request per LATENCY+1 cycles for a continuously held request.
- Reset asserted during WAIT or DONE cancels the request; any write not yet performed never occurs.
- Address is used modulo depth; there is no out-of-range condition.

## Test plan
- Reset: assert `reset` mid-cycle with no clock edge -> `ready`=0 and `output_data`=0 immediately. Deassert reset, hold `en`=0 for 5 cycles -> `ready` stays 0.
- Write then read, LATENCY=2:
  - Write 0xA5 to address 0x12 -> `ready` high one cycle after the accepting edge, for one cycle.
  - Then read address 0x12 -> `output_data`=0xA5 in the same cycle `ready` is high.
- Boundary addresses: write 0x01 to address 0x00 and 0xFE to address 0x7F, read both back -> 0x01 and 0xFE; neither write disturbs the other.
- Invalid request: `en`=1 with `read`=`write`=1, then with both 0, each for 4 cycles -> `ready` never asserts; previously written address 0x12 still reads 0xA5.
- Abort: with LATENCY=3, issue a write of 0x3C to address 0x05, then drop `en` at the edge after acceptance -> no `ready`; a later read of 0x05 returns its prior value.
- Held read, LATENCY=1: hold a read of 0x12 for 6 cycles -> `ready` pulses every other cycle (3 pulses); `output_data` stays 0xA5 throughout.

Source files
------------

// File: rtl/data_memory.sv
// Single-port synchronous data memory that completes each request after a
// fixed number of clock edges and reports completion with a one-cycle ready.
module data_memory #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 8,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  read,
    input  logic                  write,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] input_data,
    output logic [DATA_WIDTH-1:0] output_data,
    output logic                  ready
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                r_state;
    logic [3:0]            r_count;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_isWrite;
    logic                  r_ready;
    logic [DATA_WIDTH-1:0] r_outData;
    logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];

    state_t                w_nextState;
    logic [3:0]            w_nextCount;
    logic                  w_valid;
    logic                  w_latch;
    logic                  w_access;
    logic [ADDR_WIDTH-1:0] w_accAddr;
    logic [DATA_WIDTH-1:0] w_accData;
    logic                  w_accWrite;
    logic                  w_memWrite;

    assign w_valid    = en & (read ^ write);
    assign w_memWrite = w_access & w_accWrite & ~reset;

    // With LATENCY=1 the access happens on the accepting edge, so it must use
    // the live inputs; every later access uses the latched request.
    always_comb begin
        w_nextState = r_state;
        w_nextCount = r_count;
        w_latch     = 1'b0;
        w_access    = 1'b0;
        w_accAddr   = r_addr;
        w_accData   = r_data;
        w_accWrite  = r_isWrite;
        case (r_state)
            S_IDLE: begin
                if (w_valid) begin
                    w_latch = 1'b1;
                    if (LATENCY == 1) begin
                        w_access    = 1'b1;
                        w_accAddr   = address;
                        w_accData   = input_data;
                        w_accWrite  = write;
                        w_nextState = S_DONE;
                    end else begin
                        w_nextCount = 4'(LATENCY - 1);
                        w_nextState = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!en) begin
                    w_nextCount = 4'd0;
                    w_nextState = S_IDLE;
                end else begin
                    w_nextCount = r_count - 4'd1;
                    if (r_count == 4'd1) begin
                        w_access    = 1'b1;
                        w_nextState = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_nextState = S_IDLE;
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_count   <= 4'd0;
            r_addr    <= '0;
            r_data    <= '0;
            r_isWrite <= 1'b0;
            r_ready   <= 1'b0;
            r_outData <= '0;
        end else begin
            r_state <= w_nextState;
            r_count <= w_nextCount;
            r_ready <= (w_nextState == S_DONE);
            if (w_latch) begin
                r_addr    <= address;
                r_data    <= input_data;
                r_isWrite <= write;
            end
            if (w_access && !w_accWrite) begin
                r_outData <= r_mem[w_accAddr];
            end
        end
    end

    // Array contents survive reset; writes are blocked while reset is held.
    always_ff @(posedge clk) begin
        if (w_memWrite) begin
            r_mem[w_accAddr] <= w_accData;
        end
    end

    assign output_data = r_outData;
    assign ready       = r_ready;

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory: three instances (LATENCY 1, 2, 3) driven
// independently, a vector table for single requests plus multi-cycle corner cases.
module tb_data_memory;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] en;
    logic [2:0] rd;
    logic [2:0] wr;
    logic [2:0] rdy;
    logic [6:0] addr  [3];
    logic [7:0] wdata [3];
    logic [7:0] rdata [3];

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         sel;
        bit         isRead;
        logic [6:0] a;
        logic [7:0] d;
        int         expLat;
        logic [7:0] expQ;
    } vec_t;

    vec_t vecs [11];

    always #5 clk = ~clk;

    data_memory #(.LATENCY(1)) dutL1 (
        .clk(clk), .reset(reset), .en(en[0]), .read(rd[0]), .write(wr[0]),
        .address(addr[0]), .input_data(wdata[0]), .output_data(rdata[0]), .ready(rdy[0])
    );

    data_memory #(.LATENCY(2)) dutL2 (
        .clk(clk), .reset(reset), .en(en[1]), .read(rd[1]), .write(wr[1]),
        .address(addr[1]), .input_data(wdata[1]), .output_data(rdata[1]), .ready(rdy[1])
    );

    data_memory #(.LATENCY(3)) dutL3 (
        .clk(clk), .reset(reset), .en(en[2]), .read(rd[2]), .write(wr[2]),
        .address(addr[2]), .input_data(wdata[2]), .output_data(rdata[2]), .ready(rdy[2])
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // One request on instance s, held until ready (bounded), then one cycle
    // later the ready level is sampled again to confirm it was a single pulse.
    task automatic applyStimulus(input int s, input bit isRd, input logic [6:0] a, input logic [7:0] d,
                                 output int lat, output logic [7:0] q, output logic rdyAfter);
        @(negedge clk);
        en[s]    = 1'b1;
        rd[s]    = isRd;
        wr[s]    = !isRd;
        addr[s]  = a;
        wdata[s] = d;
        lat      = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (rdy[s] === 1'b1) begin
                lat = c;
                break;
            end
        end
        q     = rdata[s];
        en[s] = 1'b0;
        rd[s] = 1'b0;
        wr[s] = 1'b0;
        @(negedge clk);
        rdyAfter = rdy[s];
    endtask

    task automatic countPulses(input int s, input int cycles, output int pulses);
        pulses = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (rdy[s] !== 1'b0) pulses++;
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int         lat;
        int         pulses;
        logic [7:0] q;
        logic       after;

        reset = 1'b1;
        en    = '0;
        rd    = '0;
        wr    = '0;
        for (int i = 0; i < 3; i++) begin
            addr[i]  = '0;
            wdata[i] = '0;
        end

        vecs[0]  = '{1, 1'b0, 7'h12, 8'hA5, 2, 8'h00};
        vecs[1]  = '{1, 1'b1, 7'h12, 8'h00, 2, 8'hA5};
        vecs[2]  = '{1, 1'b0, 7'h00, 8'h01, 2, 8'hA5};
        vecs[3]  = '{1, 1'b0, 7'h7F, 8'hFE, 2, 8'hA5};
        vecs[4]  = '{1, 1'b1, 7'h00, 8'h00, 2, 8'h01};
        vecs[5]  = '{1, 1'b1, 7'h7F, 8'h00, 2, 8'hFE};
        vecs[6]  = '{1, 1'b1, 7'h12, 8'h00, 2, 8'hA5};
        vecs[7]  = '{0, 1'b0, 7'h12, 8'hA5, 1, 8'h00};
        vecs[8]  = '{0, 1'b1, 7'h12, 8'h00, 1, 8'hA5};
        vecs[9]  = '{2, 1'b0, 7'h05, 8'h77, 3, 8'h00};
        vecs[10] = '{2, 1'b1, 7'h05, 8'h00, 3, 8'h77};

        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            checkOutput($sformatf("reset ready[%0d]", s), 32'(rdy[s]), 32'd0);
            checkOutput($sformatf("reset data[%0d]", s), 32'(rdata[s]), 32'd0);
        end
        countPulses(1, 5, pulses);
        checkOutput("idle no ready", 32'(pulses), 32'd0);

        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].sel, vecs[i].isRead, vecs[i].a, vecs[i].d, lat, q, after);
            checkOutput($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].expLat));
            checkOutput($sformatf("vec%0d data", i), 32'(q), 32'(vecs[i].expQ));
            checkOutput($sformatf("vec%0d ready pulse width", i), 32'(after), 32'd0);
        end

        // Asynchronous reset away from any clock edge
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        for (int s = 0; s < 3; s++) begin
            checkOutput($sformatf("async reset ready[%0d]", s), 32'(rdy[s]), 32'd0);
            checkOutput($sformatf("async reset data[%0d]", s), 32'(rdata[s]), 32'd0);
        end
        @(negedge clk);
        reset = 1'b0;
        countPulses(1, 5, pulses);
        checkOutput("post reset idle", 32'(pulses), 32'd0);

        // Invalid request encodings never start an access
        @(negedge clk);
        en[1]   = 1'b1;
        rd[1]   = 1'b1;
        wr[1]   = 1'b1;
        addr[1] = 7'h12;
        countPulses(1, 4, pulses);
        rd[1] = 1'b0;
        wr[1] = 1'b0;
        countPulses(1, 4, lat);
        en[1] = 1'b0;
        checkOutput("invalid both set", 32'(pulses), 32'd0);
        checkOutput("invalid none set", 32'(lat), 32'd0);
        applyStimulus(1, 1'b1, 7'h12, 8'h00, lat, q, after);
        checkOutput("after invalid latency", 32'(lat), 32'd2);
        checkOutput("after invalid data", 32'(q), 32'hA5);

        // Abort: en dropped in WAIT cancels the write
        @(negedge clk);
        en[2]    = 1'b1;
        wr[2]    = 1'b1;
        addr[2]  = 7'h05;
        wdata[2] = 8'h3C;
        @(negedge clk);
        en[2] = 1'b0;
        wr[2] = 1'b0;
        countPulses(2, 6, pulses);
        checkOutput("abort no ready", 32'(pulses), 32'd0);
        applyStimulus(2, 1'b1, 7'h05, 8'h00, lat, q, after);
        checkOutput("abort readback latency", 32'(lat), 32'd3);
        checkOutput("abort readback data", 32'(q), 32'h77);

        // Reset during WAIT cancels a pending write
        @(negedge clk);
        en[2]    = 1'b1;
        wr[2]    = 1'b1;
        addr[2]  = 7'h05;
        wdata[2] = 8'h99;
        @(negedge clk);
        reset = 1'b1;
        en[2] = 1'b0;
        wr[2] = 1'b0;
        #1;
        checkOutput("reset in wait ready", 32'(rdy[2]), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(2, 1'b1, 7'h05, 8'h00, lat, q, after);
        checkOutput("reset cancel readback", 32'(q), 32'h77);

        // Held read at LATENCY=1 pulses ready every other cycle
        applyStimulus(0, 1'b1, 7'h12, 8'h00, lat, q, after);
        checkOutput("held prep data", 32'(q), 32'hA5);
        @(negedge clk);
        en[0]   = 1'b1;
        rd[0]   = 1'b1;
        addr[0] = 7'h12;
        pulses  = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (rdy[0] === 1'b1) pulses++;
            checkOutput($sformatf("held ready c%0d", c), 32'(rdy[0]), (c % 2 == 0) ? 32'd1 : 32'd0);
            checkOutput($sformatf("held data c%0d", c), 32'(rdata[0]), 32'hA5);
        end
        en[0] = 1'b0;
        rd[0] = 1'b0;
        checkOutput("held pulse count", 32'(pulses), 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
